// File: rtl/adc_window_monitor_pkg.sv
// -----------------------------------------------------------------------------
// adc_mon_pkg
// Shared definitions for the ADC window monitor: sample width, FSM state
// encoding, fault cause codes and a saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_mon_pkg;

    localparam int ADC_DATA_W = 14;

    typedef logic [1:0] state_t;
    typedef logic [1:0] fault_code_t;

    // FSM states
    localparam state_t IDLE        = 2'd0;
    localparam state_t WAIT_SAMPLE = 2'd1;
    localparam state_t CHECK       = 2'd2;

    // Fault cause codes
    localparam fault_code_t FC_NONE    = 2'b00;
    localparam fault_code_t FC_RANGE   = 2'b01;
    localparam fault_code_t FC_TIMEOUT = 2'b10;
    localparam fault_code_t FC_FORMAT  = 2'b11;

    // 4-bit increment that sticks at 15
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/adc_window_monitor_if.sv
// -----------------------------------------------------------------------------
// adc_window_monitor_if
// Bundle of all monitor signals except clk/rst.
//   master : pulse generator / ADC capture / control side (drives stimulus)
//   slave  : the monitor itself (drives results)
// Stimulus : laser_pulse, adc_data_valid, adc_data_value[15:0],
//            thr_low[13:0], thr_high[13:0], fault_clear
// Results  : sample_strobe, sample_out[13:0], fault, fault_code[1:0],
//            bad_count[3:0]; peak_max/peak_min[13:0] when ADC_MON_STATS_EN
// Optional feature macro: ADC_MON_STATS_EN
// -----------------------------------------------------------------------------
interface adc_window_monitor_if;
    import adc_mon_pkg::*;

    logic                  laser_pulse;
    logic                  adc_data_valid;
    logic [15:0]           adc_data_value;
    logic [ADC_DATA_W-1:0] thr_low;
    logic [ADC_DATA_W-1:0] thr_high;
    logic                  fault_clear;

    logic                  sample_strobe;
    logic [ADC_DATA_W-1:0] sample_out;
    logic                  fault;
    logic [1:0]            fault_code;
    logic [3:0]            bad_count;

`ifdef ADC_MON_STATS_EN
    logic [ADC_DATA_W-1:0] peak_max;
    logic [ADC_DATA_W-1:0] peak_min;

    modport master (
        output laser_pulse, adc_data_valid, adc_data_value, thr_low, thr_high, fault_clear,
        input  sample_strobe, sample_out, fault, fault_code, bad_count, peak_max, peak_min
    );
    modport slave (
        input  laser_pulse, adc_data_valid, adc_data_value, thr_low, thr_high, fault_clear,
        output sample_strobe, sample_out, fault, fault_code, bad_count, peak_max, peak_min
    );
`else
    modport master (
        output laser_pulse, adc_data_valid, adc_data_value, thr_low, thr_high, fault_clear,
        input  sample_strobe, sample_out, fault, fault_code, bad_count
    );
    modport slave (
        input  laser_pulse, adc_data_valid, adc_data_value, thr_low, thr_high, fault_clear,
        output sample_strobe, sample_out, fault, fault_code, bad_count
    );
`endif

endinterface

// File: rtl/adc_window_monitor_pulse_timer.sv
// -----------------------------------------------------------------------------
// adc_pulse_timer
// Laser pulse rising-edge detector plus the sample timeout counter.
//   clk, rst   : clock, asynchronous active-high reset
//   pulse_i    : raw laser_pulse level
//   run_i      : high while the monitor is waiting for a sample
//   arm_o      : rising edge of laser_pulse this cycle (also restarts count)
//   expire_o   : waiting and the count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module adc_pulse_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    input  logic run_i,
    output logic arm_o,
    output logic expire_o
);
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    logic       pulse_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Edge is taken against the live input so the monitor arms in the same
    // cycle the pulse rises.
    assign arm_o    = pulse_i & ~pulse_q;
    assign expire_o = run_i & (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (arm_o) begin
            cnt_d = 8'd0;
        end else if (run_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            pulse_q <= pulse_i;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_window_monitor.sv
// -----------------------------------------------------------------------------
// adc_window_monitor
// Checks each ADC sample taken after a laser pulse against a programmable
// safe window, flags missing samples, counts consecutive bad events and
// latches a safety fault with the first cause code until cleared.
//   clk, rst : clock, asynchronous active-high reset
//   mon_if   : adc_window_monitor_if.slave (stimulus in, status out)
// Optional feature macro: ADC_MON_STATS_EN adds peak_max/peak_min tracking.
// -----------------------------------------------------------------------------
module adc_window_monitor
    import adc_mon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FAULT_COUNT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_window_monitor_if.slave  mon_if
);
    localparam logic [3:0] FAULT_LIMIT = 4'(FAULT_COUNT);

    state_t                state_q, state_d;
    logic [15:0]           data_q;
    logic                  sample_strobe_q;
    logic [ADC_DATA_W-1:0] sample_out_q;
    logic                  fault_q, fault_d;
    fault_code_t           fault_code_q, fault_code_d;
    logic [3:0]            bad_count_q, bad_count_d;

    logic                  arm, expire, capture, miss_evt;
    logic                  in_check, check_bad, check_good, bad_evt, would_latch;
    fault_code_t           check_code, evt_code;
    logic [3:0]            count_inc;
    logic [ADC_DATA_W-1:0] sample_val;

    adc_pulse_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .pulse_i  (mon_if.laser_pulse),
        .run_i    (state_q == WAIT_SAMPLE),
        .arm_o    (arm),
        .expire_o (expire)
    );

    assign capture    = (state_q == WAIT_SAMPLE) & mon_if.adc_data_valid;
    assign in_check   = (state_q == CHECK);
    assign sample_val = data_q[ADC_DATA_W-1:0];

    // Next state and miss detection. A valid sample beats both a timeout and
    // a re-arming pulse in the same cycle.
    always_comb begin
        state_d  = state_q;
        miss_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) state_d = WAIT_SAMPLE;
            end
            WAIT_SAMPLE: begin
                if (mon_if.adc_data_valid) begin
                    state_d = CHECK;
                end else if (arm) begin
                    miss_evt = 1'b1;          // previous pulse never got a sample
                end else if (expire) begin
                    miss_evt = 1'b1;
                    state_d  = IDLE;
                end
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mon_if.fault_clear) state_d = IDLE;
    end

    // Sample classification; format errors take precedence over range.
    always_comb begin
        check_code = FC_NONE;
        if (data_q[15:14] != 2'b00) begin
            check_code = FC_FORMAT;
        end else if ((sample_val < mon_if.thr_low) || (sample_val > mon_if.thr_high)) begin
            check_code = FC_RANGE;
        end
    end

    assign check_bad   = in_check & (check_code != FC_NONE);
    assign check_good  = in_check & (check_code == FC_NONE);
    assign bad_evt     = miss_evt | check_bad;
    assign evt_code    = miss_evt ? FC_TIMEOUT : check_code;
    assign count_inc   = sat_inc4(bad_count_q);
    assign would_latch = bad_evt & (count_inc >= FAULT_LIMIT);

    // Bad-event counter and fault latch. A latching event in the same cycle as
    // fault_clear wins and restarts the count at one.
    always_comb begin
        bad_count_d  = bad_count_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (bad_evt) begin
            bad_count_d = count_inc;
            if (would_latch && !fault_q) begin
                fault_d      = 1'b1;
                fault_code_d = evt_code;
            end
        end else if (check_good) begin
            bad_count_d = 4'd0;
        end
        if (mon_if.fault_clear) begin
            if (would_latch) begin
                fault_d      = 1'b1;
                fault_code_d = evt_code;
                bad_count_d  = 4'd1;
            end else begin
                fault_d      = 1'b0;
                fault_code_d = FC_NONE;
                bad_count_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            data_q          <= 16'd0;
            sample_strobe_q <= 1'b0;
            sample_out_q    <= '0;
            fault_q         <= 1'b0;
            fault_code_q    <= FC_NONE;
            bad_count_q     <= 4'd0;
        end else begin
            state_q         <= state_d;
            sample_strobe_q <= in_check;
            fault_q         <= fault_d;
            fault_code_q    <= fault_code_d;
            bad_count_q     <= bad_count_d;
            if (capture)  data_q       <= mon_if.adc_data_value;
            if (in_check) sample_out_q <= sample_val;
        end
    end

    assign mon_if.sample_strobe = sample_strobe_q;
    assign mon_if.sample_out    = sample_out_q;
    assign mon_if.fault         = fault_q;
    assign mon_if.fault_code    = fault_code_q;
    assign mon_if.bad_count     = bad_count_q;

`ifdef ADC_MON_STATS_EN
    logic [ADC_DATA_W-1:0] peak_max_q;
    logic [ADC_DATA_W-1:0] peak_min_q;

    // Every accepted sample counts, good or bad; a clear always reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_max_q <= '0;
            peak_min_q <= '1;
        end else if (mon_if.fault_clear) begin
            peak_max_q <= '0;
            peak_min_q <= '1;
        end else if (in_check) begin
            if (sample_val > peak_max_q) peak_max_q <= sample_val;
            if (sample_val < peak_min_q) peak_min_q <= sample_val;
        end
    end

    assign mon_if.peak_max = peak_max_q;
    assign mon_if.peak_min = peak_min_q;
`endif

endmodule

// File: tb/tb_adc_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_adc_window_monitor
// Self-checking bench for adc_window_monitor: directed scenarios followed by
// randomized pulse/sample transactions, compared against a transaction-level
// reference model (event classification and fault bookkeeping in plain
// arithmetic). Honours ADC_MON_STATS_EN for the peak outputs.
// -----------------------------------------------------------------------------
module tb_adc_window_monitor;

    localparam int TMO  = 64;
    localparam int FCNT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adc_window_monitor_if bus ();

    adc_window_monitor #(
        .TIMEOUT_CYCLES (TMO),
        .FAULT_COUNT    (FCNT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mon_if (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // reference model state
    int          m_bad;
    bit          m_fault;
    logic [1:0]  m_code;
    logic [13:0] m_sample;
    logic [13:0] m_pmax;
    logic [13:0] m_pmin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_bad_count"}, 32'(bus.bad_count), 32'(m_bad));
        chk({tag, "_fault"}, 32'(bus.fault), 32'(m_fault));
        chk({tag, "_fault_code"}, 32'(bus.fault_code), 32'(m_code));
    endtask

    task automatic model_reset();
        m_bad    = 0;
        m_fault  = 1'b0;
        m_code   = 2'b00;
        m_sample = 14'd0;
        m_pmax   = 14'd0;
        m_pmin   = 14'h3FFF;
    endtask

    // 0 good, 1 out-of-window, 3 format
    function automatic logic [1:0] classify(input logic [15:0] v, input logic [13:0] lo,
                                            input logic [13:0] hi);
        if (v[15:14] != 2'b00) return 2'b11;
        if (v[13:0] < lo || v[13:0] > hi) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_event(input bit is_bad, input logic [1:0] code, input bit clr);
        int nb;
        nb = (m_bad >= 15) ? 15 : m_bad + 1;
        if (clr) begin
            if (is_bad && nb >= FCNT) begin
                m_fault = 1'b1;
                m_code  = code;
                m_bad   = 1;
            end else begin
                m_fault = 1'b0;
                m_code  = 2'b00;
                m_bad   = 0;
            end
            m_pmax = 14'd0;
            m_pmin = 14'h3FFF;
        end else if (is_bad) begin
            m_bad = nb;
            if (!m_fault && nb >= FCNT) begin
                m_fault = 1'b1;
                m_code  = code;
            end
        end else begin
            m_bad = 0;
        end
    endtask

    task automatic chk_peaks(input string tag);
`ifdef ADC_MON_STATS_EN
        chk({tag, "_peak_max"}, 32'(bus.peak_max), 32'(m_pmax));
        chk({tag, "_peak_min"}, 32'(bus.peak_min), 32'(m_pmin));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Called in cycle 0 of a pulse (edge already driven). delay = cycle of the
    // valid strobe relative to the edge, or TMO for a miss.
    task automatic after_edge(input int delay, input bit has_valid, input logic [15:0] val,
                              input bit clr, input bit restart_chk);
        logic [1:0] cls;
        for (int c = 1; c <= delay; c++) begin
            @(posedge clk); #1;
            if (c == 1 && restart_chk) begin
                model_event(1'b1, 2'b10, 1'b0);
                chk_status("restart_miss");
            end
            bus.laser_pulse    = 1'b0;
            bus.adc_data_valid = has_valid && (c == delay);
            bus.adc_data_value = val;
        end
        if (has_valid) begin
            @(posedge clk); #1;
            bus.adc_data_valid = 1'b0;
            bus.fault_clear    = clr;
            chk("strobe_early", 32'(bus.sample_strobe), 32'd0);
            @(posedge clk); #1;
            bus.fault_clear = 1'b0;
            cls = classify(val, bus.thr_low, bus.thr_high);
            m_sample = val[13:0];
            if (val[13:0] > m_pmax) m_pmax = val[13:0];
            if (val[13:0] < m_pmin) m_pmin = val[13:0];
            model_event(cls != 2'b00, cls, clr);
            chk("strobe", 32'(bus.sample_strobe), 32'd1);
            chk("sample_out", 32'(bus.sample_out), 32'(m_sample));
            chk_status("sample");
            chk_peaks("sample");
        end else begin
            chk("bad_before_miss", 32'(bus.bad_count), 32'(m_bad));
            @(posedge clk); #1;
            model_event(1'b1, 2'b10, 1'b0);
            chk_status("miss");
            chk("strobe_miss", 32'(bus.sample_strobe), 32'd0);
        end
    endtask

    task automatic pulse_txn(input int delay, input bit has_valid, input logic [15:0] val,
                             input bit clr);
        @(posedge clk); #1;
        bus.laser_pulse = 1'b1;
        $display("txn pulse delay=%0d valid=%0d value=%h clr=%0d thr=%0d..%0d",
                 delay, has_valid, val, clr, bus.thr_low, bus.thr_high);
        after_edge(delay, has_valid, val, clr, 1'b0);
    endtask

    // second edge at cycle gap, sample delay cycles after the second edge
    task automatic restart_txn(input int gap, input int delay, input logic [15:0] val);
        $display("txn restart gap=%0d delay=%0d value=%h", gap, delay, val);
        @(posedge clk); #1;
        bus.laser_pulse = 1'b1;
        for (int c = 1; c < gap; c++) begin
            @(posedge clk); #1;
            bus.laser_pulse = 1'b0;
        end
        @(posedge clk); #1;
        bus.laser_pulse = 1'b1;
        after_edge(delay, 1'b1, val, 1'b0, 1'b1);
    endtask

    task automatic plain_clear();
        $display("txn fault_clear");
        @(posedge clk); #1;
        bus.fault_clear = 1'b1;
        @(posedge clk); #1;
        bus.fault_clear = 1'b0;
        model_event(1'b0, 2'b00, 1'b1);
        chk_status("clear");
        chk_peaks("clear");
    endtask

    task automatic idle_noise(input logic [15:0] val);
        $display("txn idle valid value=%h", val);
        @(posedge clk); #1;
        bus.adc_data_valid = 1'b1;
        bus.adc_data_value = val;
        @(posedge clk); #1;
        bus.adc_data_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_strobe", 32'(bus.sample_strobe), 32'd0);
        chk("idle_sample_out", 32'(bus.sample_out), 32'(m_sample));
        chk_status("idle");
    endtask

    function automatic logic [15:0] rand_val();
        logic [13:0] lo, hi, b;
        lo = bus.thr_low;
        hi = bus.thr_high;
        case ($urandom_range(0, 3))
            0: return (lo <= hi) ? 16'($urandom_range(32'(hi), 32'(lo))) : 16'($urandom_range(0, 16383));
            1: return 16'($urandom_range(0, 16383));
            2: return {2'($urandom_range(1, 3)), 14'($urandom_range(0, 16383))};
            default: begin
                case ($urandom_range(0, 3))
                    0: b = lo;
                    1: b = hi;
                    2: b = lo - 14'd1;
                    default: b = hi + 14'd1;
                endcase
                return {2'b00, b};
            end
        endcase
    endfunction

    task automatic set_thr();
        logic [13:0] a, b;
        a = 14'($urandom_range(0, 16383));
        b = 14'($urandom_range(0, 16383));
        if ($urandom_range(0, 5) != 0 && a > b) begin
            bus.thr_low  = b;
            bus.thr_high = a;
        end else begin
            bus.thr_low  = a;
            bus.thr_high = b;
        end
    endtask

    initial begin
        bus.laser_pulse    = 1'b0;
        bus.adc_data_valid = 1'b0;
        bus.adc_data_value = 16'd0;
        bus.thr_low        = 14'd1000;
        bus.thr_high       = 14'd9000;
        bus.fault_clear    = 1'b0;
        model_reset();

        #2;
        chk("reset_strobe", 32'(bus.sample_strobe), 32'd0);
        chk("reset_sample_out", 32'(bus.sample_out), 32'd0);
        chk_status("reset");
        chk_peaks("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // nominal in-window sample
        pulse_txn(30, 1'b1, 16'h1388, 1'b0);
        // three out-of-window samples latch fault, then a good one
        pulse_txn(10, 1'b1, 16'd9500, 1'b0);
        pulse_txn(20, 1'b1, 16'd9500, 1'b0);
        pulse_txn(5, 1'b1, 16'd9500, 1'b0);
        pulse_txn(12, 1'b1, 16'd4000, 1'b0);
        plain_clear();
        // miss, then valid exactly on the expiry cycle
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        pulse_txn(TMO, 1'b1, 16'd5000, 1'b0);
        // format error latching after two misses, two more misses keep the code
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        pulse_txn(7, 1'b1, 16'h4005, 1'b0);
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        // clear collides with a latching bad sample
        pulse_txn(9, 1'b1, 16'd4000, 1'b0);
        pulse_txn(9, 1'b1, 16'd9500, 1'b0);
        pulse_txn(9, 1'b1, 16'd9500, 1'b0);
        pulse_txn(9, 1'b1, 16'd9500, 1'b1);
        plain_clear();
        // thresholds at the window edges
        pulse_txn(3, 1'b1, 16'd1000, 1'b0);
        pulse_txn(3, 1'b1, 16'd9000, 1'b0);
        pulse_txn(3, 1'b1, 16'd999, 1'b0);
        pulse_txn(3, 1'b1, 16'd9001, 1'b0);
        // re-armed pulse counts a miss for the first one
        restart_txn(15, 20, 16'd2000);

        // reset while waiting for a sample
        pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
        $display("txn reset during WAIT_SAMPLE");
        @(posedge clk); #1;
        bus.laser_pulse = 1'b1;
        @(posedge clk); #1;
        bus.laser_pulse = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_status("async_reset");
        chk("async_reset_sample_out", 32'(bus.sample_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.adc_data_valid = 1'b1;
        bus.adc_data_value = 16'd5000;
        @(posedge clk); #1;
        bus.adc_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_strobe", 32'(bus.sample_strobe), 32'd0);
        end
        chk("post_reset_sample_out", 32'(bus.sample_out), 32'd0);
        chk_status("post_reset");
        chk_peaks("post_reset");

        // randomized transactions
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) set_thr();
            case ($urandom_range(0, 9))
                0: idle_noise(16'($urandom));
                1: pulse_txn(TMO, 1'b0, 16'd0, 1'b0);
                2: plain_clear();
                3: restart_txn($urandom_range(2, 40), $urandom_range(1, TMO), rand_val());
                default: pulse_txn($urandom_range(1, TMO), 1'b1, rand_val(),
                                   $urandom_range(0, 7) == 0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // hard bound on simulation length
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
